// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline register with optional 2-entry skid buffer
// and synchronous flush; carries an opaque DW-bit payload.
module pipe_stage_hs #(
    parameter int              DW      = 64,
    parameter logic [DW-1:0]   RST_VAL = '0,
    parameter bit              SKID    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    count_o
);
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

    state_t        r_state;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic          w_rdy;
    logic          w_in_fire;
    logic          w_out_fire;

    // With SKID the ready is a pure state decode, so out_ready_i never reaches in_ready_o.
    assign w_rdy       = SKID ? (r_state != S_TWO) : (r_state == S_EMPTY || out_ready_i);
    assign in_ready_o  = w_rdy && !rst;
    assign out_valid_o = (r_state != S_EMPTY);
    assign out_data_o  = r_main;
    assign count_o     = r_state;
    assign w_in_fire   = in_valid_i && in_ready_o;
    assign w_out_fire  = out_valid_o && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= RST_VAL;
            r_skid  <= RST_VAL;
        end else if (flush_i) begin
            r_state <= S_EMPTY;
            r_main  <= RST_VAL;
            r_skid  <= RST_VAL;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= in_data_i;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= in_data_i;
                    end else if (w_in_fire) begin
                        r_skid  <= in_data_i;
                        r_state <= S_TWO;
                    end else if (w_out_fire) begin
                        r_main  <= RST_VAL;
                        r_state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_skid  <= RST_VAL;
                        r_state <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed stimulus for pipe_stage_hs (SKID=1 and SKID=0 instances)
// with a queue scoreboard checked by a negedge monitor.
module tb_pipe_stage_hs;
    localparam logic [63:0] RV  = 64'h0BAD_0BAD_0BAD_0BAD;
    localparam logic [7:0]  RV0 = 8'hEE;

    logic        clk = 1'b0;
    logic        rst, flush, iv, ordy, ir, ov;
    logic [63:0] id, od;
    logic [1:0]  cnt;
    logic        iv0, ordy0, ir0, ov0;
    logic [7:0]  id0, od0;
    logic [1:0]  cnt0;
    logic        flush0 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] q[$];
    logic [7:0]  q0[$];

    always #5 clk = ~clk;

    pipe_stage_hs #(.DW(64), .RST_VAL(RV), .SKID(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(ir),
        .in_data_i(id), .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od), .count_o(cnt)
    );

    pipe_stage_hs #(.DW(8), .RST_VAL(RV0), .SKID(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush_i(flush0), .in_valid_i(iv0), .in_ready_o(ir0),
        .in_data_i(id0), .out_valid_o(ov0), .out_ready_i(ordy0), .out_data_o(od0), .count_o(cnt0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on out_fire, push on in_fire, drop everything held on flush/reset.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            q0.delete();
        end else begin
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h expected no output", od);
                end else chk("sb_data", od, q.pop_front());
            end
            if (flush) q.delete();
            else if (iv && ir) q.push_back(id);
            if (ov0 && ordy0) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb0_unexpected: got %h expected no output", od0);
                end else chk("sb0_data", {56'd0, od0}, {56'd0, q0.pop_front()});
            end
            if (iv0 && ir0) q0.push_back(id0);
            chk("s0_ready_comb", {63'd0, ir0}, {63'd0, (!ov0 || ordy0)});
            chk("s0_count_le1", {63'd0, cnt0 <= 2'd1}, 64'd1);
            chk("count_not3", {63'd0, cnt != 2'd3}, 64'd1);
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; id = '0;
        iv0 = 1'b0; ordy0 = 1'b0; id0 = '0;
        cyc();
        chk("rst_ov", {63'd0, ov}, 64'd0);
        chk("rst_od", od, RV);
        chk("rst_cnt", {62'd0, cnt}, 64'd0);
        chk("rst_ir_held", {63'd0, ir}, 64'd0);
        chk("rst_od0", {56'd0, od0}, {56'd0, RV0});
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_ir_after", {63'd0, ir}, 64'd1);

        // Streaming: each payload appears one cycle after it is driven.
        cyc();
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iv = 1'b1;
            id = 64'h10 + 64'(i);
            cyc();
            chk("stream_od", od, 64'h10 + 64'(i));
            chk("stream_ir", {63'd0, ir}, 64'd1);
            chk("stream_cnt", {62'd0, cnt}, 64'd1);
        end
        iv = 1'b0;
        cyc();
        chk("stream_drain_cnt", {62'd0, cnt}, 64'd0);
        chk("stream_drain_od", od, RV);

        // Backpressure into the skid register.
        ordy = 1'b0; iv = 1'b1; id = 64'hA;
        cyc();
        chk("bp_cnt1", {62'd0, cnt}, 64'd1);
        id = 64'hB;
        cyc();
        chk("bp_cnt2", {62'd0, cnt}, 64'd2);
        chk("bp_ir0", {63'd0, ir}, 64'd0);
        chk("bp_hold_a", od, 64'hA);
        id = 64'hC;
        cyc();
        chk("bp_c_rejected_cnt", {62'd0, cnt}, 64'd2);
        chk("bp_stable_od", od, 64'hA);
        chk("bp_stable_ov", {63'd0, ov}, 64'd1);
        ordy = 1'b1;
        cyc();
        chk("bp_rel_b", od, 64'hB);
        chk("bp_rel_cnt", {62'd0, cnt}, 64'd1);
        cyc();
        chk("bp_rel_c", od, 64'hC);
        iv = 1'b0;
        cyc();
        chk("bp_empty", {62'd0, cnt}, 64'd0);

        // Simultaneous in/out fire in ONE.
        ordy = 1'b0; iv = 1'b1; id = 64'h5;
        cyc();
        chk("sim_main5", od, 64'h5);
        ordy = 1'b1; id = 64'h6;
        cyc();
        chk("sim_od6", od, 64'h6);
        chk("sim_cnt1", {62'd0, cnt}, 64'd1);
        chk("sim_skid_unused", u_dut.r_skid, RV);
        iv = 1'b0;
        cyc();

        // Flush while full, with an incoming payload that must be discarded.
        ordy = 1'b0; iv = 1'b1; id = 64'h7;
        cyc();
        id = 64'h8;
        cyc();
        chk("fl_pre_cnt", {62'd0, cnt}, 64'd2);
        id = 64'h9; flush = 1'b1;
        cyc();
        flush = 1'b0; iv = 1'b0; ordy = 1'b1;
        chk("fl_ov", {63'd0, ov}, 64'd0);
        chk("fl_od", od, RV);
        chk("fl_cnt", {62'd0, cnt}, 64'd0);
        chk("fl_skid", u_dut.r_skid, RV);
        cyc();
        cyc();
        chk("fl_still_empty", {63'd0, ov}, 64'd0);

        // Asynchronous reset between edges while full.
        ordy = 1'b0; iv = 1'b1; id = 64'h1;
        cyc();
        id = 64'h2;
        cyc();
        iv = 1'b0;
        chk("ar_pre_cnt", {62'd0, cnt}, 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_ov", {63'd0, ov}, 64'd0);
        chk("ar_od", od, RV);
        chk("ar_cnt", {62'd0, cnt}, 64'd0);
        chk("ar_ir", {63'd0, ir}, 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("ar_ir_after", {63'd0, ir}, 64'd1);

        // SKID=0: combinational ready, single entry.
        ordy0 = 1'b1; iv0 = 1'b1; id0 = 8'h31;
        cyc();
        chk("s0_od31", {56'd0, od0}, 64'h31);
        chk("s0_cnt1", {62'd0, cnt0}, 64'd1);
        ordy0 = 1'b0; id0 = 8'h32;
        #1 chk("s0_ir_low", {63'd0, ir0}, 64'd0);
        cyc();
        chk("s0_hold31", {56'd0, od0}, 64'h31);
        ordy0 = 1'b1;
        #1 chk("s0_ir_high", {63'd0, ir0}, 64'd1);
        cyc();
        chk("s0_od32", {56'd0, od0}, 64'h32);
        iv0 = 1'b0;
        cyc();
        chk("s0_empty", {62'd0, cnt0}, 64'd0);
        cyc();

        chk("sb_drained", 64'(q.size()), 64'd0);
        chk("sb0_drained", 64'(q0.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline stage register, the successor to the fixed-field ID/EX hold-enable register.
- Replaces the global hold_n stall with a per-stage valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM). It carries an opaque payload, which the instantiating stage packs and unpacks.
- It cuts the backward ready path, so stalls stay local to the stage.

Parameters:
- DW, 64: payload width in bits, at least 1.
- RST_VAL, {DW{1'b0}}: payload value after reset or flush. This is the bubble encoding, e.g. the NOP control fields.
- SKID, 1: 1 gives a 2-entry skid buffer with registered in_ready_o. 0 gives a single register with combinational ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous kill of all held entries
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept a payload this cycle
- in_data_i  in  DW  upstream payload
- out_valid_o  out  1  out_data_o holds a valid payload
- out_ready_i  in  1  downstream accepts this cycle
- out_data_o  out  DW  payload to the next stage
- count_o  out  2  number of held entries, 0..2

Behaviour:
- Transfer definitions:
  - in_fire = in_valid_i & in_ready_o
  - out_fire = out_valid_o & out_ready_i
- Reset (rst=1, asynchronous):
  - state EMPTY, out_valid_o=0, out_data_o=RST_VAL, skid register=RST_VAL, count_o=0.
  - in_ready_o=1 once rst deasserts. It is held at 0 while rst=1.
- SKID=1 state machine. Registers are main (drives out_data_o) and skid.
  - EMPTY, count 0:
    - in_fire -> main<=in_data_i, go to ONE.
  - ONE, count 1:
    - in_fire & out_fire -> main<=in_data_i, stay in ONE.
    - in_fire & !out_fire -> skid<=in_data_i, go to TWO.
    - !in_fire & out_fire -> main<=RST_VAL, go to EMPTY.
    - Neither -> hold.
  - TWO, count 2:
    - in_ready_o=0.
    - out_fire -> main<=skid, skid<=RST_VAL, go to ONE.
- SKID=1 outputs:
  - out_valid_o = (state != EMPTY).
  - in_ready_o = (state != TWO), taken from a flop.
  - No combinational path from out_ready_i to in_ready_o.
- SKID=0 mode:
  - States are EMPTY and ONE only.
  - in_ready_o = !out_valid_o | out_ready_i, combinational.
  - in_fire loads main. out_fire without in_fire empties the stage.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid_o.
  - Sustained throughput is 1 payload per cycle when out_ready_i=1.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o must not change. The only exceptions are flush_i and rst.
- Ordering: strict FIFO. No payload is duplicated or dropped, except by flush.
- Flush (flush_i=1 at an edge), highest priority after rst:
  - Next state EMPTY; main=skid=RST_VAL; count_o=0.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle counts as consumed downstream.
- count_o mirrors the state: EMPTY=0, ONE=1, TWO=2. It is never 3.
- Width rules: the payload passes through unmodified. No sign or zero extension.

Test Plan:
- Streaming:
  - Stimulus: SKID=1, DW=64, out_ready_i=1, 8 back-to-back payloads 0x10..0x17.
  - Response: out_data_o shows 0x10..0x17 on consecutive cycles, each 1 cycle after its input; in_ready_o stays 1; count_o=1.
- Backpressure:
  - Stimulus: out_ready_i=0, push 0xA, 0xB, then attempt 0xC.
  - Response: count_o reaches 2; in_ready_o=0 on the cycle after 0xB is accepted; 0xC is not accepted; out_data_o holds 0xA.
  - Then release out_ready_i: output order is 0xA, 0xB, 0xC.
- Simultaneous fire in ONE:
  - Stimulus: main=0x5, in_fire with 0x6 and out_fire in the same cycle.
  - Response: next cycle out_data_o=0x6, count_o=1, and the skid register is unused.
- Flush in TWO:
  - Stimulus: count_o=2 and flush_i=1 together with in_valid_i=1 (data 0x9).
  - Response: next cycle out_valid_o=0, out_data_o=RST_VAL, count_o=0, and 0x9 never appears at the output.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between edges while count_o=2.
  - Response: out_valid_o=0, out_data_o=RST_VAL and count_o=0 immediately, without waiting for an edge; in_ready_o=1 on the first cycle after deassert.
- SKID=0 mode:
  - Stimulus: out_ready_i toggles 1,0,1 while in_valid_i=1.
  - Response: in_ready_o follows !out_valid_o | out_ready_i combinationally; no payload is lost; count_o never exceeds 1.
